maze_row_mem: RTL and testbench
===============================

// Module: maze_row_mem
// PURPOSE
//  Parametrised maze-map storage: DEPTH rows of ROW_W bits, one bit per maze cell.
//  Separate read and write ports with a bit-level write mask and registered, 1-cycle reads.
//  Self-clears to INIT_VAL after reset or on request.
//  Sits between the maze generator (writer) and the VGA renderer / player-move logic (readers).
// PARAMETERS
//  ROW_W     64  bits per row (cells per maze row)
//  DEPTH     64  number of rows; 2..2**ADDR_W
//  ADDR_W    6   address width
//  INIT_VAL  0   ROW_W-bit value written to every row by a clear sweep
// PORTS
//  clk       in   1       system clock, 50 MHz
//  rst       in   1       synchronous, active-high reset
//  clr_req   in   1       start a clear sweep (pulse)
//  busy      out  1       clear sweep in progress
//  wr_en     in   1       write strobe
//  wr_addr   in   ADDR_W  write row address
//  wr_data   in   ROW_W   write data
//  wr_mask   in   ROW_W   1 = update bit, 0 = keep stored bit
//  rd_en     in   1       read request
//  rd_addr   in   ADDR_W  read row address
//  rd_valid  out  1       1-cycle pulse: rd_data carries the answer to last cycle's rd_en
//  rd_data   out  ROW_W   read data; held between reads
//  addr_err  out  1       1-cycle pulse: an accepted access used an address >= DEPTH
// BEHAVIOUR
//  Reset values: busy=1, rd_valid=0, rd_data=0, addr_err=0, FSM=CLEAR, clr_ptr=0.
//  FSM states:
//   CLEAR: each cycle writes mem[clr_ptr] <= INIT_VAL, then clr_ptr++.
//          At clr_ptr==DEPTH-1 -> IDLE; that row is written on the same cycle.
//          The sweep takes exactly DEPTH cycles.
//   IDLE:  normal access. clr_req=1 -> CLEAR with clr_ptr=0; busy=1 on the next cycle.
//  During CLEAR:
//   - wr_en and rd_en are ignored: no write, rd_valid stays 0, no addr_err.
//   - clr_req is ignored.
//  rst at any time, including mid-sweep, restarts CLEAR from row 0.
//  Write (IDLE, wr_en=1, wr_addr<DEPTH):
//   - mem[a] <= (mem[a] & ~wr_mask) | (wr_data & wr_mask) at the clock edge.
//  Read (IDLE, rd_en=1, rd_addr<DEPTH):
//   - rd_data <= mem[rd_addr] at the edge and rd_valid=1 for that following cycle.
//   - Latency is exactly 1. Back-to-back reads give one result per cycle.
//  Address >= DEPTH:
//   - A write is dropped.
//   - A read returns rd_data=0 with rd_valid=1.
//   - addr_err=1 for one cycle. It is asserted once even if both ports err together.
//  clr_req and wr_en/rd_en in the same IDLE cycle:
//   - The access completes first.
//   - CLEAR starts the next cycle and overwrites that row.
//  Simultaneous read and write, different rows: both complete independently.
//  Simultaneous read and write, same row: see CONFIGURATION.
//  No wrap-around: addresses are never incremented outside CLEAR.
// CONFIGURATION
//  MAZE_MEM_FWD_EN defined:
//   - Same-row read-during-write returns the merged new row
//     (old & ~wr_mask) | (wr_data & wr_mask).
//  MAZE_MEM_FWD_EN undefined:
//   - Same-row read-during-write returns the old row (read-before-write).
//   - No bypass logic is generated.
// TESTING
//  1 rst 1 cycle, then idle:
//    busy=1 for exactly 64 cycles, then 0.
//    Every row then reads 0 with rd_valid one cycle after each rd_en.
//  2 IDLE, wr addr 5, data 64'hFFFF_0000_FFFF_0000, mask all-1, then a read of addr 5:
//    rd_data=64'hFFFF_0000_FFFF_0000.
//    Then wr addr 5, data 0, mask 64'h0000_0000_0000_00FF, then read:
//    rd_data=64'hFFFF_0000_FFFF_0000 (low byte was already 0).
//    Then wr data 64'hAA, same mask, then read: rd_data=64'hFFFF_0000_FFFF_00AA.
//  3 Row 9=64'h1, same-cycle wr addr 9 data 64'h2 mask all-1 and rd addr 9:
//    FWD_EN -> rd_data=64'h2; no FWD_EN -> rd_data=64'h1.
//    A following read gives 64'h2 in both builds.
//  4 DEPTH=48: wr addr 50 then rd addr 50:
//    addr_err pulses on both accesses.
//    rd_data=0 with rd_valid=1; rows 0..47 unchanged.
//  5 After writing rows 0..63 nonzero: assert clr_req, then rst 20 cycles later.
//    busy stays 1 for 64 cycles after rst deasserts.
//    All rows read INIT_VAL.
//    wr_en and rd_en asserted during busy: no write, rd_valid=0.
//  6 Back-to-back reads of rows 0,1,2 on consecutive cycles:
//    rd_valid=1 for 3 consecutive cycles.
//    Data arrives in order, each one cycle after its rd_en.

Source files
------------

// File: rtl/maze_row_mem_if.sv
// Bus bundle for maze_row_mem: clear control, masked write port, registered read port.
// The generator/renderer side uses master; the memory uses slave.
interface maze_row_mem_if #(
    parameter int ROW_W  = 64,
    parameter int ADDR_W = 6
);
    logic              clr_req;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ROW_W-1:0]  wr_data;
    logic [ROW_W-1:0]  wr_mask;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [ROW_W-1:0]  rd_data;
    logic              addr_err;

    modport master (
        output clr_req, wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
        input  busy, rd_valid, rd_data, addr_err
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data, wr_mask, rd_en, rd_addr,
        output busy, rd_valid, rd_data, addr_err
    );
endinterface

// File: rtl/maze_row_mem.sv
// Maze-map row storage with masked writes, 1-cycle registered reads and a self-clear sweep.
// Define MAZE_MEM_FWD_EN to forward same-row write data into a concurrent read.
module maze_row_mem #(
    parameter int              ROW_W    = 64,
    parameter int              DEPTH    = 64,
    parameter int              ADDR_W   = 6,
    parameter logic [ROW_W-1:0] INIT_VAL = '0
) (
    input logic          clk,
    input logic          rst,
    maze_row_mem_if.slave bus
);
    // state    | meaning
    // ST_CLEAR | sweeping INIT_VAL into every row, accesses ignored
    // ST_IDLE  | normal read/write access
    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
    logic              idle;

    logic [ROW_W-1:0]  mem [DEPTH];

    logic              wr_ok, rd_ok, wr_do;
    logic [ROW_W-1:0]  merged, rd_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        idle        = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (clr_ptr == LAST_ROW) begin
                    state_nxt   = ST_IDLE;
                    clr_ptr_nxt = '0;
                end else begin
                    clr_ptr_nxt = clr_ptr + 1'b1;
                end
            end
            ST_IDLE: begin
                idle = 1'b1;
                if (bus.clr_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_ptr_nxt = '0;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign bus.busy = (state == ST_CLEAR);

    assign wr_ok  = ({1'b0, bus.wr_addr} < DEPTH_V);
    assign rd_ok  = ({1'b0, bus.rd_addr} < DEPTH_V);
    assign wr_do  = idle & bus.wr_en & wr_ok;
    assign merged = (mem[bus.wr_addr] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);

`ifdef MAZE_MEM_FWD_EN
    assign rd_row = (wr_do && (bus.wr_addr == bus.rd_addr)) ? merged : mem[bus.rd_addr];
`else
    assign rd_row = mem[bus.rd_addr];
`endif

    // Storage has no reset of its own; the sweep that follows reset initialises it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR)
                mem[clr_ptr] <= INIT_VAL;
            else if (wr_do)
                mem[bus.wr_addr] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.addr_err <= 1'b0;
        end else begin
            bus.rd_valid <= idle & bus.rd_en;
            bus.addr_err <= idle & ((bus.wr_en & ~wr_ok) | (bus.rd_en & ~rd_ok));
            if (idle && bus.rd_en)
                bus.rd_data <= rd_ok ? rd_row : '0;
        end
    end
endmodule

// File: tb/tb_maze_row_mem.sv
// Self-checking bench for maze_row_mem: a 64-row and a 48-row instance driven in lockstep
// and compared every cycle against an array-based reference model.
module tb_maze_row_mem;
`ifdef MAZE_MEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, clr_req, wr_en, rd_en;
    logic [5:0]  wr_addr, rd_addr;
    logic [63:0] wr_data, wr_mask;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    maze_row_mem_if #(.ROW_W(64), .ADDR_W(6)) if64 ();
    maze_row_mem_if #(.ROW_W(64), .ADDR_W(6)) if48 ();

    assign if64.clr_req = clr_req; assign if48.clr_req = clr_req;
    assign if64.wr_en   = wr_en;   assign if48.wr_en   = wr_en;
    assign if64.wr_addr = wr_addr; assign if48.wr_addr = wr_addr;
    assign if64.wr_data = wr_data; assign if48.wr_data = wr_data;
    assign if64.wr_mask = wr_mask; assign if48.wr_mask = wr_mask;
    assign if64.rd_en   = rd_en;   assign if48.rd_en   = rd_en;
    assign if64.rd_addr = rd_addr; assign if48.rd_addr = rd_addr;

    maze_row_mem #(.ROW_W(64), .DEPTH(64), .ADDR_W(6), .INIT_VAL(64'h0)) u_dut64 (
        .clk(clk), .rst(rst), .bus(if64));
    maze_row_mem #(.ROW_W(64), .DEPTH(48), .ADDR_W(6), .INIT_VAL(64'h0)) u_dut48 (
        .clk(clk), .rst(rst), .bus(if48));

    // Reference model: index 0 = 64-row instance, 1 = 48-row instance.
    int          depth_of [2] = '{64, 48};
    logic [63:0] mdl_mem  [2][64];
    int          mdl_busy [2];
    logic [63:0] exp_data [2];
    logic        exp_valid[2];
    logic        exp_err  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int dep = depth_of[d];
            bit wok = (int'(wr_addr) < dep);
            bit rok = (int'(rd_addr) < dep);
            if (rst) begin
                mdl_busy[d] = dep;
                exp_valid[d] = 1'b0; exp_data[d] = '0; exp_err[d] = 1'b0;
            end else if (mdl_busy[d] > 0) begin
                mdl_mem[d][dep - mdl_busy[d]] = 64'h0;
                mdl_busy[d]--;
                exp_valid[d] = 1'b0; exp_err[d] = 1'b0;
            end else begin
                logic [63:0] nrow = 64'h0;
                if (wok) nrow = (mdl_mem[d][wr_addr] & ~wr_mask) | (wr_data & wr_mask);
                exp_valid[d] = rd_en;
                if (rd_en) begin
                    if (!rok) exp_data[d] = 64'h0;
                    else if (FWD && wr_en && wok && wr_addr == rd_addr) exp_data[d] = nrow;
                    else exp_data[d] = mdl_mem[d][rd_addr];
                end
                if (wr_en && wok) mdl_mem[d][wr_addr] = nrow;
                exp_err[d] = (wr_en && !wok) || (rd_en && !rok);
                if (clr_req) mdl_busy[d] = dep;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("d64_busy",  {63'h0, if64.busy},     {63'h0, mdl_busy[0] > 0});
        chk("d64_valid", {63'h0, if64.rd_valid}, {63'h0, exp_valid[0]});
        chk("d64_err",   {63'h0, if64.addr_err}, {63'h0, exp_err[0]});
        chk("d64_data",  if64.rd_data,           exp_data[0]);
        chk("d48_busy",  {63'h0, if48.busy},     {63'h0, mdl_busy[1] > 0});
        chk("d48_valid", {63'h0, if48.rd_valid}, {63'h0, exp_valid[1]});
        chk("d48_err",   {63'h0, if48.addr_err}, {63'h0, exp_err[1]});
        chk("d48_data",  if48.rd_data,           exp_data[1]);
    endtask

    task automatic drive(input logic c, input logic we, input logic [5:0] wa,
                         input logic [63:0] wd, input logic [63:0] wm,
                         input logic re, input logic [5:0] ra);
        clr_req = c; wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_en = re; rd_addr = ra;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 1'b0, 6'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mdl_busy[0] > 0 || mdl_busy[1] > 0) && n < 200) begin
            tick();
            n++;
        end
        chk("wait_idle_bound", {63'h0, n >= 200}, 64'h0);
    endtask

    task automatic read_all();
        for (int r = 0; r < 64; r++) begin
            drive(1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 1'b1, 6'(r));
            tick();
        end
        idle_in();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        foreach (mdl_mem[d, r]) mdl_mem[d][r] = 64'h0;
        mdl_busy = '{64, 48};
        tick();
        rst = 1'b0;

        // Sweep after reset: 64-row busy must hold for exactly 64 cycles.
        for (int i = 0; i < 63; i++) tick();
        chk("t1_busy_last", {63'h0, if64.busy}, 64'h1);
        tick();
        chk("t1_busy_done", {63'h0, if64.busy}, 64'h0);
        read_all();

        // Masked writes to row 5.
        drive(1'b0, 1'b1, 6'd5, 64'hFFFF_0000_FFFF_0000, '1, 1'b0, 6'd0); tick();
        drive(1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 1'b1, 6'd5); tick();
        chk("t2_full", if64.rd_data, 64'hFFFF_0000_FFFF_0000);
        drive(1'b0, 1'b1, 6'd5, 64'h0, 64'hFF, 1'b0, 6'd0); tick();
        drive(1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 1'b1, 6'd5); tick();
        chk("t2_mask0", if64.rd_data, 64'hFFFF_0000_FFFF_0000);
        drive(1'b0, 1'b1, 6'd5, 64'hAA, 64'hFF, 1'b0, 6'd0); tick();
        drive(1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 1'b1, 6'd5); tick();
        chk("t2_maskAA", if64.rd_data, 64'hFFFF_0000_FFFF_00AA);

        // Same-row read during write.
        drive(1'b0, 1'b1, 6'd9, 64'h1, '1, 1'b0, 6'd0); tick();
        drive(1'b0, 1'b1, 6'd9, 64'h2, '1, 1'b1, 6'd9); tick();
        chk("t3_rdw", if64.rd_data, FWD ? 64'h2 : 64'h1);
        drive(1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 1'b1, 6'd9); tick();
        chk("t3_after", if64.rd_data, 64'h2);

        // Out-of-range access on the 48-row instance.
        drive(1'b0, 1'b1, 6'd50, 64'hDEAD_BEEF, '1, 1'b0, 6'd0); tick();
        chk("t4_wr_err", {63'h0, if48.addr_err}, 64'h1);
        drive(1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 1'b1, 6'd50); tick();
        chk("t4_rd_err", {63'h0, if48.addr_err}, 64'h1);
        chk("t4_rd_valid", {63'h0, if48.rd_valid}, 64'h1);
        chk("t4_rd_zero", if48.rd_data, 64'h0);
        drive(1'b0, 1'b1, 6'd60, 64'h5, '1, 1'b1, 6'd61); tick();
        idle_in(); tick();

        // Back-to-back reads of rows 0,1,2.
        for (int r = 0; r < 3; r++) begin
            drive(1'b0, 1'b0, 6'd0, 64'h0, 64'h0, 1'b1, 6'(r));
            tick();
            chk("t6_valid", {63'h0, if64.rd_valid}, 64'h1);
        end
        idle_in(); tick();

        // Fill every row, request a clear, then reset mid-sweep with accesses attempted.
        for (int r = 0; r < 64; r++) begin
            drive(1'b0, 1'b1, 6'(r), {$urandom, $urandom} | 64'h1, '1, 1'b0, 6'd0);
            tick();
        end
        read_all();
        drive(1'b1, 1'b0, 6'd0, 64'h0, 64'h0, 1'b0, 6'd0); tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 6'($urandom_range(63)), {$urandom, $urandom}, '1,
                  1'b1, 6'($urandom_range(63)));
            tick();
        end
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, 6'($urandom_range(63)), {$urandom, $urandom}, '1,
                  1'b1, 6'($urandom_range(63)));
            tick();
            if (i == 62) chk("t5_busy_hold", {63'h0, if64.busy}, 64'h1);
        end
        chk("t5_busy_done", {63'h0, if64.busy}, 64'h0);
        idle_in();
        read_all();

        // Randomised traffic, including occasional clear requests and resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(199) == 0);
            drive($urandom_range(39) == 0, $urandom_range(1) == 1, 6'($urandom_range(63)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(1) == 1, 6'($urandom_range(63)));
            tick();
        end
        rst = 1'b0;
        idle_in();
        wait_idle();
        read_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
